frogger_game_ctrl: RTL and testbench
====================================

# frogger_game_ctrl

Game-level sequencer for the Frogger top level. It watches the per-row car and lilypad collision flags, the frog position and the decoded arrow/start keys, and runs the play/death/level-up/game-over state machine. It owns lives, level and BCD score, and drives the frog respawn pulse and the global freeze that halts frog, car-row and lilypad-row motion. It sits beside `color_mapper`, clocked by `Clk`, and takes the VGA vertical sync as its frame reference.

## Interface
Parameters:
- LIVES_INIT, 3: lives at game start (1–3).
- DEATH_FRAMES, 60: frames spent in DYING.
- LEVELUP_FRAMES, 90: frames spent in LEVEL_UP.
- GOAL_Y, 40: frog top Y at or above which the goal is reached.
- RIVER_Y_TOP / RIVER_Y_BOT, 80 / 239: inclusive Y band of the lilypad rows.
- MAX_LEVEL, 7: level saturation value.
- GOAL_POINTS, 50: score added per goal.

Ports:
- Clk, in, 1: 50 MHz system clock.
- Reset_n, in, 1: reset, asynchronous and active-low.
- VS, in, 1: VGA vertical sync, synchronous to Clk.
- Car_Collision, in, 4: per-row car hit flags.
- LPad_Collision, in, 4: per-row frog-on-pad flags.
- Frog_Y, in, 11: frog top Y.
- Up, in, 1: up-arrow held.
- Start, in, 1: start key held.
- Game_State, out, 3: current `game_state_t`.
- Lives, out, 2: remaining lives.
- Level, out, 3: current level (1..MAX_LEVEL).
- Score_BCD, out, 12: three BCD digits, 000–999.
- Frog_Reset, out, 1: one-Clk pulse that returns the frog to its start position.
- Freeze, out, 1: high = all motion halted.

## Operation
- frame_tick = VS & ~VS_q, where VS_q is a one-cycle registered copy of VS. All game decisions are evaluated only on frame_tick.
- Start_pulse and Up_pulse are rising edges of Start and Up, each edge-detected on Clk.
- States: IDLE, PLAY, DYING, LEVEL_UP, GAME_OVER.
- IDLE or GAME_OVER, on Start_pulse:
  - Go to PLAY.
  - Lives ← LIVES_INIT, Level ← 1, Score ← 000.
  - Pulse Frog_Reset.
- PLAY, on frame_tick:
  - death = |Car_Collision, or (Frog_Y within [RIVER_Y_TOP, RIVER_Y_BOT] and ~|LPad_Collision).
  - goal = Frog_Y ≤ GOAL_Y.
  - If death: go to DYING, Lives ← Lives−1, load the frame counter with DEATH_FRAMES−1.
  - Else if goal: go to LEVEL_UP, Score += GOAL_POINTS, load the frame counter with LEVELUP_FRAMES−1.
  - Death has priority over goal on the same tick.
- PLAY, on Up_pulse (any cycle): Score += 1.
- DYING: the counter decrements on each frame_tick. At 0:
  - If Lives == 0, go to GAME_OVER.
  - Otherwise go to PLAY and pulse Frog_Reset.
- LEVEL_UP: the counter decrements on each frame_tick. At 0:
  - Go to PLAY, Level ← min(Level+1, MAX_LEVEL), pulse Frog_Reset.
- Freeze = (state != PLAY).
- Score arithmetic: 3-digit BCD add with digit carry. Any result above 999 saturates to 999. An Up_pulse and a goal add in the same cycle sum before saturating.
- Start_pulse in PLAY, DYING or LEVEL_UP is ignored. Up_pulse outside PLAY is ignored.
- Frame counter: 7 bits, wide enough for values up to 127. Parameters must not exceed 128.

## Timing
- Reset values (asynchronous):
  - Game_State = IDLE, Lives = 0, Level = 1, Score_BCD = 000.
  - Frog_Reset = 0, Freeze = 1, VS_q = 0, counter = 0.
- All outputs are registered.
- Game_State changes on the Clk edge that samples frame_tick, or Start_pulse in IDLE/GAME_OVER.
- Frog_Reset is high for exactly the one cycle following the edge that enters PLAY.
- Score updates one cycle after the Up edge or goal tick.
- DYING lasts exactly DEATH_FRAMES frame_ticks. LEVEL_UP lasts exactly LEVELUP_FRAMES frame_ticks.
- Asserting Reset_n low mid-game returns everything to reset values immediately. Nothing resumes until Start is pressed after reset is released.

## Structure
- `frogger_pkg`: `game_state_t` enum (3 bits), default parameter constants, and `bcd3_t` typedef.
- One sub-module: `bcd_score_adder`. It is combinational: 12-bit BCD plus an 8-bit binary increment (0..GOAL_POINTS+1), with saturation at 999.
- Everything else (edge detectors, FSM, frame counter, lives/level registers) stays in `frogger_game_ctrl`.

## Test plan
- Reset, then a Start pulse → PLAY, Lives=3, Level=1, Score=000, one-cycle Frog_Reset, Freeze=0.
- In PLAY, Car_Collision=4'b0100 on a frame_tick → DYING, Lives=2, Freeze=1. After 60 ticks → PLAY with a Frog_Reset pulse.
- Frog_Y=150, LPad_Collision=0 on a tick → death. Frog_Y=150, LPad_Collision=4'b0010 → no death.
- Frog_Y=30 and Car_Collision=4'b0001 on the same tick → DYING, not LEVEL_UP, score unchanged. Frog_Y=30 alone → LEVEL_UP, Score +50. After 90 ticks → Level=2.
- Three deaths from Lives=3 → GAME_OVER after the third DYING. Start then restarts with Score=000.
- Score preset to 995: five Up pulses → 999 and held there; a goal at 999 stays at 999. Reset asserted in DYING → IDLE, Lives=0.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and default constants for the Frogger game-level controller.
package frogger_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPlay     = 3'd1,
      StDying    = 3'd2,
      StLevelUp  = 3'd3,
      StGameOver = 3'd4
   } game_state_t;

   typedef struct packed {
      logic [3:0] hund;
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd3_t;

   localparam int unsigned DefLivesInit    = 3;
   localparam int unsigned DefDeathFrames  = 60;
   localparam int unsigned DefLevelupFrames = 90;
   localparam int unsigned DefGoalY        = 40;
   localparam int unsigned DefRiverYTop    = 80;
   localparam int unsigned DefRiverYBot    = 239;
   localparam int unsigned DefMaxLevel     = 7;
   localparam int unsigned DefGoalPoints   = 50;
   localparam int unsigned FrameCntW       = 7;

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// Game-level signal bundle: collision/position/key inputs and game status outputs.
interface frogger_game_ctrl_if;
   import frogger_pkg::*;

   logic        VS;
   logic [3:0]  Car_Collision;
   logic [3:0]  LPad_Collision;
   logic [10:0] Frog_Y;
   logic        Up;
   logic        Start;
   game_state_t Game_State;
   logic [1:0]  Lives;
   logic [2:0]  Level;
   bcd3_t       Score_BCD;
   logic        Frog_Reset;
   logic        Freeze;

   // Master is the surrounding top level (drives game inputs), slave is the controller.
   modport master (
      output VS, Car_Collision, LPad_Collision, Frog_Y, Up, Start,
      input  Game_State, Lives, Level, Score_BCD, Frog_Reset, Freeze
   );

   modport slave (
      input  VS, Car_Collision, LPad_Collision, Frog_Y, Up, Start,
      output Game_State, Lives, Level, Score_BCD, Frog_Reset, Freeze
   );

endinterface

// File: rtl/bcd_score_adder.sv
// Combinational 3-digit BCD score plus small binary increment, saturating at 999.
module bcd_score_adder
   import frogger_pkg::*;
(
   input  bcd3_t      score,
   input  logic [7:0] inc,
   output bcd3_t      sum
);

   logic [10:0] bin_raw;
   logic [9:0]  bin_sat;
   logic [21:0] sh;

   always_comb begin
      bin_raw = 11'(score.hund) * 11'd100 + 11'(score.tens) * 11'd10
              + 11'(score.ones) + 11'(inc);
      bin_sat = (bin_raw > 11'd999) ? 10'd999 : bin_raw[9:0];
      // Double-dabble back to BCD: digits live in sh[21:10].
      sh = {12'd0, bin_sat};
      for (int i = 0; i < 10; i++) begin
         for (int d = 0; d < 3; d++) begin
            if (sh[10+4*d +: 4] >= 4'd5) begin
               sh[10+4*d +: 4] = sh[10+4*d +: 4] + 4'd3;
            end
         end
         sh = {sh[20:0], 1'b0};
      end
      sum = bcd3_t'(sh[21:10]);
   end

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: play/death/level-up/game-over FSM, lives, level and BCD score.
module frogger_game_ctrl
   import frogger_pkg::*;
#(
   parameter int unsigned LIVES_INIT     = DefLivesInit,
   parameter int unsigned DEATH_FRAMES   = DefDeathFrames,
   parameter int unsigned LEVELUP_FRAMES = DefLevelupFrames,
   parameter int unsigned GOAL_Y         = DefGoalY,
   parameter int unsigned RIVER_Y_TOP    = DefRiverYTop,
   parameter int unsigned RIVER_Y_BOT    = DefRiverYBot,
   parameter int unsigned MAX_LEVEL      = DefMaxLevel,
   parameter int unsigned GOAL_POINTS    = DefGoalPoints
) (
   input logic                Clk,
   input logic                Reset_n,
   frogger_game_ctrl_if.slave bus
);

   logic vs_q, start_q, up_q;
   logic frame_tick, start_pulse, up_pulse;

   game_state_t          state_q, state_d;
   logic [FrameCntW-1:0] cnt_q, cnt_d;
   logic [1:0]           lives_q, lives_d;
   logic [2:0]           level_q, level_d;
   bcd3_t                score_q, score_d, score_sum;
   logic [7:0]           score_inc;
   logic                 restart;
   logic                 frog_reset_q, freeze_q;
   logic                 in_river, death, goal;

   assign frame_tick  = bus.VS & ~vs_q;
   assign start_pulse = bus.Start & ~start_q;
   assign up_pulse    = bus.Up & ~up_q;

   assign in_river = (bus.Frog_Y >= 11'(RIVER_Y_TOP)) && (bus.Frog_Y <= 11'(RIVER_Y_BOT));
   assign death    = (|bus.Car_Collision) || (in_river && ~|bus.LPad_Collision);
   assign goal     = bus.Frog_Y <= 11'(GOAL_Y);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lives_d   = lives_q;
      level_d   = level_q;
      score_inc = 8'd0;
      restart   = 1'b0;
      case (state_q)
         StIdle, StGameOver: begin
            if (start_pulse) begin
               state_d = StPlay;
               lives_d = 2'(LIVES_INIT);
               level_d = 3'd1;
               restart = 1'b1;
            end
         end
         StPlay: begin
            if (up_pulse) score_inc = 8'd1;
            if (frame_tick) begin
               if (death) begin
                  state_d = StDying;
                  lives_d = lives_q - 2'd1;
                  cnt_d   = FrameCntW'(DEATH_FRAMES - 1);
               end else if (goal) begin
                  state_d   = StLevelUp;
                  score_inc = score_inc + 8'(GOAL_POINTS);
                  cnt_d     = FrameCntW'(LEVELUP_FRAMES - 1);
               end
            end
         end
         StDying: begin
            if (frame_tick) begin
               if (cnt_q == '0) begin
                  state_d = (lives_q == 2'd0) ? StGameOver : StPlay;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         StLevelUp: begin
            if (frame_tick) begin
               if (cnt_q == '0) begin
                  state_d = StPlay;
                  level_d = (level_q >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level_q + 3'd1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   bcd_score_adder u_score_adder (
      .score (score_q),
      .inc   (score_inc),
      .sum   (score_sum)
   );

   always_comb begin
      score_d = score_q;
      if (restart)                score_d = '0;
      else if (score_inc != 8'd0) score_d = score_sum;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_q         <= 1'b0;
         start_q      <= 1'b0;
         up_q         <= 1'b0;
         state_q      <= StIdle;
         cnt_q        <= '0;
         lives_q      <= 2'd0;
         level_q      <= 3'd1;
         score_q      <= '0;
         frog_reset_q <= 1'b0;
         freeze_q     <= 1'b1;
      end else begin
         vs_q         <= bus.VS;
         start_q      <= bus.Start;
         up_q         <= bus.Up;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lives_q      <= lives_d;
         level_q      <= level_d;
         score_q      <= score_d;
         frog_reset_q <= (state_d == StPlay) && (state_q != StPlay);
         freeze_q     <= (state_d != StPlay);
      end
   end

   assign bus.Game_State = state_q;
   assign bus.Lives      = lives_q;
   assign bus.Level      = level_q;
   assign bus.Score_BCD  = score_q;
   assign bus.Frog_Reset = frog_reset_q;
   assign bus.Freeze     = freeze_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed self-checking bench for frogger_game_ctrl with hand-computed expectations.
module tb_frogger_game_ctrl;
   import frogger_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   fr_cnt  = 0;
   int   fr0;

   localparam logic [31:0] Idle = 0, Play = 1, Dying = 2, LvlUp = 3, Over = 4;

   frogger_game_ctrl_if bus ();

   frogger_game_ctrl dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles in which Frog_Reset is high, to verify single-cycle pulses.
   always @(posedge clk) if (bus.Frog_Reset) fr_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk) bus.VS = 1'b1;
      @(negedge clk) bus.VS = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic press_up();
      @(negedge clk) bus.Up = 1'b1;
      @(negedge clk) bus.Up = 1'b0;
   endtask

   task automatic press_start();
      @(negedge clk) bus.Start = 1'b1;
      @(negedge clk) bus.Start = 1'b0;
   endtask

   task automatic goal_cycle();
      bus.Frog_Y = 11'd40;
      tick();
      bus.Frog_Y = 11'd300;
      ticks(90);
   endtask

   function automatic logic [31:0] st();
      return {29'd0, bus.Game_State};
   endfunction

   function automatic logic [31:0] sc();
      return {20'd0, bus.Score_BCD};
   endfunction

   initial begin
      rst_n              = 1'b0;
      bus.VS             = 1'b0;
      bus.Car_Collision  = 4'd0;
      bus.LPad_Collision = 4'd0;
      bus.Frog_Y         = 11'd300;
      bus.Up             = 1'b0;
      bus.Start          = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", st(), Idle);
      check("rst_lives", {30'd0, bus.Lives}, 0);
      check("rst_level", {29'd0, bus.Level}, 1);
      check("rst_score", sc(), 'h000);
      check("rst_frog_reset", {31'd0, bus.Frog_Reset}, 0);
      check("rst_freeze", {31'd0, bus.Freeze}, 1);
      rst_n = 1'b1;

      press_up();
      tick();
      check("idle_up_ignored", sc(), 'h000);
      check("idle_stays", st(), Idle);

      fr0 = fr_cnt;
      press_start();
      check("start_state", st(), Play);
      check("start_lives", {30'd0, bus.Lives}, 3);
      check("start_level", {29'd0, bus.Level}, 1);
      check("start_frog_reset_hi", {31'd0, bus.Frog_Reset}, 1);
      check("start_freeze", {31'd0, bus.Freeze}, 0);
      @(negedge clk);
      check("start_frog_reset_lo", {31'd0, bus.Frog_Reset}, 0);
      check("start_fr_pulse_len", fr_cnt - fr0, 1);

      press_up();
      check("up1", sc(), 'h001);
      press_up();
      check("up2", sc(), 'h002);

      bus.Car_Collision = 4'b0100;
      tick();
      bus.Car_Collision = 4'd0;
      check("car_dying", st(), Dying);
      check("car_lives", {30'd0, bus.Lives}, 2);
      check("car_freeze", {31'd0, bus.Freeze}, 1);
      fr0 = fr_cnt;
      ticks(59);
      check("dying_59", st(), Dying);
      tick();
      check("dying_60_play", st(), Play);
      check("dying_fr_pulse", fr_cnt - fr0, 1);

      bus.Frog_Y = 11'd79;
      tick();
      check("y79_safe", st(), Play);
      bus.Frog_Y = 11'd240;
      tick();
      check("y240_safe", st(), Play);
      bus.Frog_Y = 11'd41;
      tick();
      check("y41_no_goal", st(), Play);
      bus.Frog_Y = 11'd150;
      bus.LPad_Collision = 4'b0010;
      tick();
      check("on_pad_safe", st(), Play);
      bus.LPad_Collision = 4'd0;
      tick();
      check("drown", st(), Dying);
      check("drown_lives", {30'd0, bus.Lives}, 1);
      bus.Frog_Y = 11'd300;
      ticks(60);
      check("drown_back", st(), Play);

      bus.Frog_Y = 11'd30;
      bus.Car_Collision = 4'b0001;
      tick();
      bus.Car_Collision = 4'd0;
      bus.Frog_Y = 11'd300;
      check("death_over_goal", st(), Dying);
      check("death_goal_score", sc(), 'h002);
      check("death3_lives", {30'd0, bus.Lives}, 0);
      press_start();
      check("dying_start_ignored", st(), Dying);
      press_up();
      check("dying_up_ignored", sc(), 'h002);
      fr0 = fr_cnt;
      ticks(60);
      check("game_over", st(), Over);
      check("game_over_freeze", {31'd0, bus.Freeze}, 1);
      check("game_over_no_fr", fr_cnt - fr0, 0);

      press_start();
      check("restart_state", st(), Play);
      check("restart_score", sc(), 'h000);
      check("restart_lives", {30'd0, bus.Lives}, 3);

      bus.Frog_Y = 11'd30;
      tick();
      bus.Frog_Y = 11'd300;
      check("goal_state", st(), LvlUp);
      check("goal_score", sc(), 'h050);
      ticks(89);
      check("lvlup_89", st(), LvlUp);
      check("lvlup_89_level", {29'd0, bus.Level}, 1);
      fr0 = fr_cnt;
      tick();
      check("lvlup_done", st(), Play);
      check("level2", {29'd0, bus.Level}, 2);
      check("lvlup_fr_pulse", fr_cnt - fr0, 1);

      // Up edge and goal tick on the same clock edge.
      @(negedge clk);
      bus.Frog_Y = 11'd40;
      bus.VS     = 1'b1;
      bus.Up     = 1'b1;
      @(negedge clk);
      bus.VS     = 1'b0;
      bus.Up     = 1'b0;
      bus.Frog_Y = 11'd300;
      @(negedge clk);
      check("up_plus_goal", sc(), 'h101);
      ticks(90);
      check("level3", {29'd0, bus.Level}, 3);

      repeat (17) goal_cycle();
      check("score_951", sc(), 'h951);
      check("level_sat", {29'd0, bus.Level}, 7);
      repeat (44) press_up();
      check("score_995", sc(), 'h995);
      repeat (4) press_up();
      check("score_999", sc(), 'h999);
      press_up();
      check("score_sat_up", sc(), 'h999);
      bus.Frog_Y = 11'd40;
      tick();
      bus.Frog_Y = 11'd300;
      check("goal_at_999_state", st(), LvlUp);
      check("goal_at_999_score", sc(), 'h999);
      ticks(90);
      check("level_held_7", {29'd0, bus.Level}, 7);

      bus.Car_Collision = 4'b1000;
      tick();
      bus.Car_Collision = 4'd0;
      check("pre_reset_dying", st(), Dying);
      ticks(5);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", st(), Idle);
      check("async_rst_lives", {30'd0, bus.Lives}, 0);
      check("async_rst_score", sc(), 'h000);
      check("async_rst_level", {29'd0, bus.Level}, 1);
      check("async_rst_freeze", {31'd0, bus.Freeze}, 1);
      @(negedge clk) rst_n = 1'b1;
      ticks(3);
      check("post_rst_idle", st(), Idle);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
